// File: rtl/pmu_stream_tx_pkg.sv
// Shared constants, state type and helpers for the PMU configuration-link serializer.
package pmu_stream_tx_pkg;

  localparam int unsigned HEADER_WIDTH   = 32;
  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned TAIL_CYCLES    = 140;
  localparam int unsigned LEN_WIDTH      = HEADER_WIDTH - 4;
  localparam int unsigned WORD_IDX_WIDTH = $clog2(WORD_WIDTH);
  // Wide enough for ceil((2^LEN_WIDTH - 1) / WORD_WIDTH).
  localparam int unsigned WORDS_WIDTH    = LEN_WIDTH + 1 - WORD_IDX_WIDTH;
  localparam int unsigned TAIL_CNT_WIDTH = $clog2(TAIL_CYCLES);

  localparam logic [3:0] OP_PC_SC  = 4'b1010;
  localparam logic [3:0] OP_PC_MEM = 4'b0001;
  localparam logic [3:0] OP_KEY    = 4'b0010;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StHeader,
    StPayload,
    StTail
  } tx_state_e;

  function automatic logic is_legal_op(logic [3:0] op);
    return (op == OP_PC_SC) || (op == OP_PC_MEM) || (op == OP_KEY);
  endfunction

  function automatic logic [WORDS_WIDTH-1:0] words_for_len(logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] sum;
    sum = {1'b0, len} + (LEN_WIDTH + 1)'(WORD_WIDTH - 1);
    return WORDS_WIDTH'(sum >> WORD_IDX_WIDTH);
  endfunction

endpackage

// File: rtl/pmu_stream_tx_if.sv
// Command and payload-word handshake bundle between the host bridge and the serializer.
interface pmu_stream_tx_if;
  import pmu_stream_tx_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_opcode;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_data;

  modport master (
    output cmd_valid, cmd_opcode, cmd_len, word_valid, word_data,
    input  cmd_ready, word_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_len, word_valid, word_data,
    output cmd_ready, word_ready
  );
endinterface

// File: rtl/pmu_tx_word_buf.sv
// One-entry valid/ready holding buffer between the payload word port and the shift register.
module pmu_tx_word_buf
  import pmu_stream_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data
);

  logic                  valid_q;
  logic [WORD_WIDTH-1:0] data_q;

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready && out_valid) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pmu_stream_tx.sv
// Serializes a PMU command (en pulse, LSB-first header, payload bits, idle drain) onto en_o/data_o.
module pmu_stream_tx
  import pmu_stream_tx_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  pmu_stream_tx_if.slave bus,
  output logic           en_o,
  output logic           data_o,
  output logic           busy,
  output logic           done,
  output logic           err
);

  tx_state_e state_q, state_d;

  logic [HEADER_WIDTH-1:0]   hdr_q, hdr_d;
  logic [LEN_WIDTH-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TAIL_CNT_WIDTH-1:0] tail_cnt_q, tail_cnt_d;
  logic [WORD_WIDTH-1:0]     sr_q, sr_d;
  logic [WORDS_WIDTH-1:0]    words_left_q, words_left_d;
  logic                      err_d, en_d, done_d;

  logic                  cmd_ready, cmd_fire, cmd_legal;
  logic                  word_phase, word_open, word_fire;
  logic                  buf_in_ready, buf_out_valid, buf_pop, reload;
  logic [WORD_WIDTH-1:0] buf_out_data;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic                  hdr_last, payload_last, word_end, tail_last;

  assign hdr_len      = hdr_q[HEADER_WIDTH-1:4];
  assign cmd_legal    = is_legal_op(bus.cmd_opcode);
  assign cmd_fire     = bus.cmd_valid && cmd_ready;
  assign hdr_last     = (bit_cnt_q == LEN_WIDTH'(HEADER_WIDTH - 1));
  assign payload_last = (bit_cnt_q == hdr_len - LEN_WIDTH'(1));
  assign word_end     = &bit_cnt_q[WORD_IDX_WIDTH-1:0];
  assign tail_last    = (tail_cnt_q == TAIL_CNT_WIDTH'(TAIL_CYCLES - 1));
  assign word_open    = word_phase && (words_left_q != '0);
  assign word_fire    = bus.word_valid && bus.word_ready;

  assign bus.cmd_ready  = cmd_ready;
  assign bus.word_ready = buf_in_ready && word_open;
  // data_o comes straight off a flop; the shift register is kept zero outside the bit phases.
  assign data_o         = sr_q[0];

  pmu_tx_word_buf u_word_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (cmd_fire),
    .in_valid  (bus.word_valid && word_open),
    .in_ready  (buf_in_ready),
    .in_data   (bus.word_data),
    .out_valid (buf_out_valid),
    .out_ready (buf_pop),
    .out_data  (buf_out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_fire && cmd_legal) state_d = StStart;
      StStart:   state_d = StHeader;
      StHeader:  if (hdr_last) state_d = (hdr_len != '0) ? StPayload : StTail;
      StPayload: if (payload_last) state_d = StTail;
      StTail:    if (tail_last) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    word_phase = (state_q == StStart) || (state_q == StHeader) || (state_q == StPayload);
    en_d       = (state_d == StStart);
    done_d     = (state_q == StTail) && (state_d == StIdle);
  end

  always_comb begin
    hdr_d        = hdr_q;
    err_d        = err;
    bit_cnt_d    = bit_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    sr_d         = sr_q;
    words_left_d = word_fire ? words_left_q - WORDS_WIDTH'(1) : words_left_q;
    buf_pop      = 1'b0;
    reload       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          hdr_d        = {bus.cmd_len, bus.cmd_opcode};
          err_d        = !cmd_legal;
          words_left_d = cmd_legal ? words_for_len(bus.cmd_len) : '0;
          bit_cnt_d    = '0;
          tail_cnt_d   = '0;
        end
      end
      StStart: begin
        sr_d      = WORD_WIDTH'(hdr_q);
        bit_cnt_d = '0;
      end
      StHeader: begin
        if (hdr_last) begin
          bit_cnt_d = '0;
          if (hdr_len != '0) reload = 1'b1;
          else               sr_d   = '0;
        end else begin
          sr_d      = sr_q >> 1;
          bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
        end
      end
      StPayload: begin
        if (payload_last) begin
          sr_d      = '0;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
          if (word_end) reload = 1'b1;
          else          sr_d   = sr_q >> 1;
        end
      end
      StTail:  tail_cnt_d = tail_last ? '0 : tail_cnt_q + TAIL_CNT_WIDTH'(1);
      default: ;
    endcase
    // An empty buffer at a word boundary sends zeros for that word rather than stalling.
    if (reload) begin
      buf_pop = 1'b1;
      sr_d    = buf_out_valid ? buf_out_data : '0;
      if (!buf_out_valid) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q        <= '0;
      bit_cnt_q    <= '0;
      tail_cnt_q   <= '0;
      sr_q         <= '0;
      words_left_q <= '0;
      err          <= 1'b0;
      en_o         <= 1'b0;
      done         <= 1'b0;
    end else begin
      hdr_q        <= hdr_d;
      bit_cnt_q    <= bit_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      sr_q         <= sr_d;
      words_left_q <= words_left_d;
      err          <= err_d;
      en_o         <= en_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_pmu_stream_tx.sv
// Randomized scoreboard bench: expected line bits are queued per command and checked by a monitor.
module tb_pmu_stream_tx;
  import pmu_stream_tx_pkg::*;

  typedef struct {
    int unsigned nbits;
    int unsigned len;
    bit          err;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic en_o, data_o, busy, done, err;

  always #5 clk = ~clk;

  pmu_stream_tx_if bus ();

  pmu_stream_tx dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .en_o   (en_o),
    .data_o (data_o),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  frame_t      exp_frames[$];
  bit          exp_bits[$];
  logic [31:0] drv_words[$];
  bit          drv_skip[$];
  bit          drv_extra;
  int unsigned drv_max_delay;
  bit          drv_busy = 1'b0;

  int          word_fires  = 0;
  int          frames_done = 0;
  int          wr_viol     = 0;
  bit          mon_active  = 1'b0;
  frame_t      mon_frame;
  int unsigned mon_left, mon_busy_cnt, mon_idx;
  logic [31:0] mon_hdr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) word_fires++;
  end

  // Monitor: frames begin at the en pulse and are checked bit by bit against the queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      exp_bits.delete();
      exp_frames.delete();
    end else begin
      if (!busy && bus.word_ready) wr_viol++;
      if (mon_active && mon_frame.len == 0 && bus.word_ready && !en_o) wr_viol++;
      if (en_o) begin
        if (mon_active || exp_frames.size() == 0) begin
          check("en_unexpected", en_o, 1'b0);
        end else begin
          mon_frame    = exp_frames.pop_front();
          mon_active   = 1'b1;
          mon_left     = mon_frame.nbits;
          mon_busy_cnt = busy ? 1 : 0;
          mon_idx      = 0;
          mon_hdr      = '0;
          check("start_data", data_o, 1'b0);
        end
      end else if (mon_active) begin
        if (busy) mon_busy_cnt++;
        if (mon_left > 0) begin
          check("data_bit", data_o, exp_bits.pop_front());
          if (mon_idx < 32) mon_hdr[mon_idx] = data_o;
          mon_idx++;
          mon_left--;
        end else begin
          check("done_pulse", done, 1'b1);
          check("busy_cycles", mon_busy_cnt, 1 + 32 + mon_frame.len + TAIL_CYCLES);
          check("err_at_done", err, mon_frame.err);
          mon_active = 1'b0;
          frames_done++;
        end
      end else begin
        if (done)   check("done_unexpected", done, 1'b0);
        if (data_o) check("idle_data", data_o, 1'b0);
      end
    end
  end

  task automatic send_cmd(input logic [3:0] op, input logic [27:0] len);
    int t = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_len    = len;
    while (!bus.cmd_ready && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.cmd_ready) check("cmd_accept_timeout", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_words();
    drv_busy = 1'b1;
    for (int i = 0; i < drv_words.size(); i++) begin
      int t = 0;
      if (drv_skip[i]) continue;
      repeat ($urandom_range(0, drv_max_delay)) @(posedge clk);
      #1;
      bus.word_valid = 1'b1;
      bus.word_data  = drv_words[i];
      while (!bus.word_ready && t < 2000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!bus.word_ready) check("word_accept_timeout", bus.word_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.word_valid = 1'b0;
    end
    if (drv_extra) begin
      bus.word_valid = 1'b1;
      bus.word_data  = 32'hDEAD_BEEF;
      repeat (250) @(posedge clk);
      #1;
      bus.word_valid = 1'b0;
    end
    drv_busy = 1'b0;
  endtask

  // Reference: header bits, then payload bits (zero for a word never delivered), then the drain gap.
  task automatic prep_frame(input logic [3:0] op, input int unsigned len, input int unsigned max_dly,
                            input bit extra, input int skip_idx, input bit key_pattern,
                            output int unsigned exp_fires);
    frame_t      f;
    int unsigned nw = (len + 31) / 32;
    logic [27:0] l28 = len[27:0];
    logic [31:0] hdr = {l28, op};
    logic [31:0] w;
    drv_words.delete();
    drv_skip.delete();
    exp_fires = 0;
    for (int i = 0; i < nw; i++) begin
      w = key_pattern ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom;
      drv_words.push_back(w);
      drv_skip.push_back(i == skip_idx);
      if (i != skip_idx) exp_fires++;
    end
    for (int i = 0; i < 32; i++) exp_bits.push_back(hdr[i]);
    for (int i = 0; i < len; i++) begin
      w = drv_words[i/32];
      exp_bits.push_back(drv_skip[i/32] ? 1'b0 : w[i%32]);
    end
    for (int i = 0; i < TAIL_CYCLES; i++) exp_bits.push_back(1'b0);
    f.nbits = 32 + len + TAIL_CYCLES;
    f.len   = len;
    f.err   = (exp_fires != nw);
    exp_frames.push_back(f);
    drv_max_delay = max_dly;
    drv_extra     = extra;
  endtask

  task automatic run_frame(input logic [3:0] op, input int unsigned len, input int unsigned max_dly,
                           input bit extra, input int skip_idx, input bit key_pattern);
    int unsigned exp_fires;
    int          fires0, done0;
    int          t = 0;
    prep_frame(op, len, max_dly, extra, skip_idx, key_pattern, exp_fires);
    fires0 = word_fires;
    done0  = frames_done;
    send_cmd(op, len[27:0]);
    check("err_clear_on_cmd", err, 1'b0);
    check("busy_after_cmd", busy, 1'b1);
    fork
      drive_words();
    join_none
    while (frames_done == done0 && t < int'(len) + 1000) begin
      @(posedge clk);
      t++;
    end
    if (frames_done == done0) check("frame_timeout", frames_done, done0 + 1);
    t = 0;
    #1;
    while (drv_busy && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("word_transfers", word_fires - fires0, exp_fires);
  endtask

  initial begin
    int unsigned exp_fires;
    logic [3:0]  ops[3];
    ops[0] = OP_PC_SC;
    ops[1] = OP_PC_MEM;
    ops[2] = OP_KEY;

    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_len    = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    #3;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_word_ready", bus.word_ready, 1'b0);
    check("rst_outputs", {en_o, data_o, busy, done, err}, 5'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Key load with the byte-ramp pattern; header must read 0x802 on the line.
    run_frame(OP_KEY, 128, 8, 1'b0, -1, 1'b1);
    check("hdr_key128", mon_hdr, 32'h0000_0802);

    run_frame(OP_PC_SC, 256, 0, 1'b0, -1, 1'b0);

    // Partial last word with a junk word held offered afterwards.
    run_frame(OP_PC_MEM, 40, 5, 1'b1, -1, 1'b0);
    check("hdr_pcmem40", mon_hdr, 32'h0000_0281);

    run_frame(OP_KEY, 0, 3, 1'b1, -1, 1'b0);
    check("word_ready_violations", wr_viol, 0);

    send_cmd(4'b0111, 28'd16);
    check("illegal_err", err, 1'b1);
    check("illegal_idle", {busy, bus.cmd_ready}, 2'b01);
    repeat (20) @(posedge clk);
    #1;
    check("illegal_err_sticky", err, 1'b1);

    run_frame(OP_PC_MEM, 64, 4, 1'b0, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame(ops[$urandom_range(0, 2)], $urandom_range(0, 300), $urandom_range(0, 15),
                1'b0, -1, 1'b0);
    end
    check("word_ready_violations_final", wr_viol, 0);

    // Reset in the middle of the payload aborts immediately.
    prep_frame(OP_PC_MEM, 64, 0, 1'b0, -1, 1'b0, exp_fires);
    send_cmd(OP_PC_MEM, 28'd64);
    fork
      drive_words();
    join_none
    repeat (50) @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs", {en_o, data_o, busy, done, err}, 5'b0);
    check("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check("abort_word_ready", bus.word_ready, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_frame(OP_KEY, 33, 10, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
